// File: rtl/io_timer_irq_if.sv
// io_timer_irq_if: dma_io peripheral bus slice seen by one device on the read-data chain.
interface io_timer_irq_if;
  logic        dma_io_we;
  logic [13:0] dma_io_wadr;
  logic [31:0] dma_io_wdata;
  logic [13:0] dma_io_radr;
  logic        dma_io_radr_en;
  logic [31:0] dma_io_rdata_in;
  logic [31:0] dma_io_rdata;
  modport master (
    output dma_io_we, dma_io_wadr, dma_io_wdata, dma_io_radr, dma_io_radr_en, dma_io_rdata_in,
    input  dma_io_rdata
  );
  modport slave (
    input  dma_io_we, dma_io_wadr, dma_io_wdata, dma_io_radr, dma_io_radr_en, dma_io_rdata_in,
    output dma_io_rdata
  );
endinterface

// File: rtl/io_timer_irq.sv
// io_timer_irq: prescaled interval timer with compare, one-shot/auto-reload and level irq.
module io_timer_irq (
  input  logic           clk,
  input  logic           rst,
  io_timer_irq_if.slave  bus,
  output logic           timer_irq
);
  localparam logic [13:0] TIMER_BASE = 14'h3C00;
  logic        en_q, en_d, ie_q, ie_d, ar_q, ar_d, pend_q, pend_d, irq_q, irq_d, hit_q, hit_d;
  logic [15:0] pre_q, pre_d, ps_q, ps_d;
  logic [31:0] cnt_q, cnt_d, cmp_q, cmp_d, rdata_q, rdata_d;
  logic [13:0] woff, roff;
  logic        wsel, w_ctrl, w_pre, w_cnt, w_cmp, w_st, clr, tick, match;
  always_comb begin
    woff    = bus.dma_io_wadr - TIMER_BASE;
    roff    = bus.dma_io_radr - TIMER_BASE;
    wsel    = bus.dma_io_we && woff < 14'd5;
    w_ctrl  = wsel && woff[2:0] == 3'd0;
    w_pre   = wsel && woff[2:0] == 3'd1;
    w_cnt   = wsel && woff[2:0] == 3'd2;
    w_cmp   = wsel && woff[2:0] == 3'd3;
    w_st    = wsel && woff[2:0] == 3'd4;
    clr     = w_ctrl && bus.dma_io_wdata[3];
    tick    = en_q && ps_q == pre_q;
    match   = cnt_q == cmp_q;
    en_d    = w_ctrl ? bus.dma_io_wdata[0] : en_q;
    ie_d    = w_ctrl ? bus.dma_io_wdata[1] : ie_q;
    ar_d    = w_ctrl ? bus.dma_io_wdata[2] : ar_q;
    pre_d   = w_pre ? bus.dma_io_wdata[15:0] : pre_q;
    ps_d    = (!en_q || tick || w_pre || clr) ? 16'd0 : ps_q + 16'd1;
    // software writes beat the tick; the compare still uses the old count
    cnt_d   = w_cnt ? bus.dma_io_wdata :
              clr ? 32'd0 :
              !tick ? cnt_q :
              (match && ar_q) ? 32'd0 : cnt_q + 32'd1;
    cmp_d   = w_cmp ? bus.dma_io_wdata : cmp_q;
    pend_d  = (tick && match) || (pend_q && !(w_st && bus.dma_io_wdata[0]));
    irq_d   = pend_q && ie_q;
    hit_d   = bus.dma_io_radr_en && roff < 14'd5;
    rdata_d = roff[2:0] == 3'd0 ? {29'd0, ar_q, ie_q, en_q} :
              roff[2:0] == 3'd1 ? {16'd0, pre_q} :
              roff[2:0] == 3'd2 ? cnt_q :
              roff[2:0] == 3'd3 ? cmp_q : {30'd0, en_q, pend_q};
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      en_q    <= 1'b0;
      ie_q    <= 1'b0;
      ar_q    <= 1'b0;
      pend_q  <= 1'b0;
      irq_q   <= 1'b0;
      hit_q   <= 1'b0;
      pre_q   <= '0;
      ps_q    <= '0;
      cnt_q   <= '0;
      cmp_q   <= '0;
      rdata_q <= '0;
    end else begin
      en_q    <= en_d;
      ie_q    <= ie_d;
      ar_q    <= ar_d;
      pend_q  <= pend_d;
      irq_q   <= irq_d;
      hit_q   <= hit_d;
      pre_q   <= pre_d;
      ps_q    <= ps_d;
      cnt_q   <= cnt_d;
      cmp_q   <= cmp_d;
      rdata_q <= rdata_d;
    end
  end
  assign bus.dma_io_rdata = hit_q ? rdata_q : bus.dma_io_rdata_in;
  assign timer_irq        = irq_q;
endmodule

// File: tb/tb_io_timer_irq.sv
// tb_io_timer_irq: directed stimulus with queued expectations checked by an independent monitor.
module tb_io_timer_irq;
  localparam logic [13:0] B = 14'h3C00;
  logic clk = 1'b0, rst = 1'b1, timer_irq;
  logic irq_req = 1'b0, rd_v = 1'b0, irq_v = 1'b0;
  int errors = 0, checks = 0;
  logic [31:0] rd_exp[$];
  string       rd_nm[$];
  logic        irq_exp[$];
  string       irq_nm[$];
  io_timer_irq_if bus();
  io_timer_irq dut (.clk(clk), .rst(rst), .bus(bus), .timer_irq(timer_irq));
  always #5 clk = ~clk;
  always @(posedge clk) begin
    rd_v  <= bus.dma_io_radr_en;
    irq_v <= irq_req;
  end
  always @(negedge clk) begin
    logic [31:0] e;
    logic        ei;
    string       n;
    if (rd_v) begin
      checks++;
      if (rd_exp.size() == 0) begin
        errors++;
        $display("FAIL rd_underflow: rdata=%h with no expectation", bus.dma_io_rdata);
      end else begin
        e = rd_exp.pop_front();
        n = rd_nm.pop_front();
        if (bus.dma_io_rdata !== e) begin
          errors++;
          $display("FAIL %s: rdata=%h expected=%h", n, bus.dma_io_rdata, e);
        end
      end
    end
    if (irq_v) begin
      checks++;
      if (irq_exp.size() == 0) begin
        errors++;
        $display("FAIL irq_underflow: timer_irq=%b with no expectation", timer_irq);
      end else begin
        ei = irq_exp.pop_front();
        n  = irq_nm.pop_front();
        if (timer_irq !== ei) begin
          errors++;
          $display("FAIL %s: timer_irq=%b expected=%b", n, timer_irq, ei);
        end
      end
    end
  end
  task automatic clk1;
    @(posedge clk);
    #1;
    bus.dma_io_we      = 1'b0;
    bus.dma_io_radr_en = 1'b0;
    irq_req            = 1'b0;
  endtask
  task automatic set_wr(input logic [13:0] a, input logic [31:0] d);
    bus.dma_io_we    = 1'b1;
    bus.dma_io_wadr  = a;
    bus.dma_io_wdata = d;
  endtask
  task automatic set_rd(input logic [13:0] a, input logic [31:0] e, input string n);
    bus.dma_io_radr    = a;
    bus.dma_io_radr_en = 1'b1;
    rd_exp.push_back(e);
    rd_nm.push_back(n);
  endtask
  task automatic set_irq(input logic e, input string n);
    irq_req = 1'b1;
    irq_exp.push_back(e);
    irq_nm.push_back(n);
  endtask
  task automatic wr(input logic [13:0] a, input logic [31:0] d);
    set_wr(a, d);
    clk1();
  endtask
  task automatic rd(input logic [13:0] a, input logic [31:0] e, input string n);
    set_rd(a, e, n);
    clk1();
  endtask
  initial begin
    logic [31:0] seq [6];
    int t;
    seq = '{0, 1, 2, 0, 1, 2};
    bus.dma_io_we = 1'b0; bus.dma_io_wadr = '0; bus.dma_io_wdata = '0;
    bus.dma_io_radr = '0; bus.dma_io_radr_en = 1'b0; bus.dma_io_rdata_in = 32'hA5A5_0001;
    repeat (2) clk1();
    set_rd(B, 32'hA5A5_0001, "rst_chain");
    set_irq(1'b0, "rst_irq");
    clk1();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) rd(B + 14'(i), 32'h0, "rst_reg");
    // one-shot: tick every 4 cycles, match on the 6th tick
    wr(B + 14'd1, 3);
    wr(B + 14'd3, 5);
    wr(B, 3);
    repeat (23) clk1();
    set_rd(B + 14'd4, 2, "os_pend_before"); set_irq(1'b0, "os_irq_before"); clk1();
    set_rd(B + 14'd4, 3, "os_pend_set");    set_irq(1'b1, "os_irq_rise");   clk1();
    rd(B + 14'd2, 6, "os_count_after");
    repeat (2) clk1();
    rd(B + 14'd2, 7, "os_count_keeps");
    // reset mid-count drops the in-flight read
    rst = 1'b1;
    set_rd(B + 14'd2, 32'hA5A5_0001, "midrst_read");
    set_irq(1'b0, "midrst_irq");
    clk1();
    rst = 1'b0;
    // periodic: tick every cycle, reload after 2
    wr(B + 14'd3, 2);
    wr(B, 7);
    for (int i = 0; i < 6; i++) begin
      set_rd(B + 14'd2, seq[i], "per_count");
      if (i == 2) set_irq(1'b0, "per_irq_low");
      if (i == 3) set_irq(1'b1, "per_irq_high");
      clk1();
    end
    set_wr(B + 14'd4, 1); set_irq(1'b1, "w1c_irq_hold"); clk1();
    set_rd(B + 14'd4, 2, "w1c_pend"); set_irq(1'b0, "w1c_irq_fall"); clk1();
    wr(B + 14'd4, 1);
    rd(B + 14'd4, 3, "w1c_vs_set");
    wr(B + 14'd2, 32'h10);
    rd(B + 14'd2, 32'h10, "count_wr_vs_tick");
    // wrap from all-ones without setting PEND
    wr(B, 0);
    wr(B + 14'd2, 32'hFFFF_FFFF);
    wr(B + 14'd3, 5);
    wr(B + 14'd4, 1);
    wr(B, 1);
    rd(B + 14'd2, 32'hFFFF_FFFF, "wrap_start");
    rd(B + 14'd2, 0, "wrap_zero");
    rd(B + 14'd4, 2, "wrap_no_pend");
    repeat (3) clk1();
    rd(B + 14'd4, 2, "wrap_pre_match");
    set_rd(B + 14'd4, 3, "wrap_match"); set_irq(1'b0, "wrap_irq_masked"); clk1();
    // CLR zeroes count and reads back as 0
    wr(B, 9);
    rd(B + 14'd2, 0, "clr_count");
    rd(B + 14'd2, 1, "clr_restart");
    rd(B, 1, "ctrl_read");
    wr(B + 14'd1, 32'hFFFF_1234);
    rd(B + 14'd1, 32'h1234, "prescale_mask");
    // read chain
    bus.dma_io_rdata_in = 32'h1234_5678;
    rd(B + 14'd5, 32'h1234_5678, "chain_above");
    rd(B - 14'd1, 32'h1234_5678, "chain_below");
    wr(B + 14'd3, 32'hDEAD_BEEF);
    bus.dma_io_rdata_in = 32'h0;
    rd(B + 14'd3, 32'hDEAD_BEEF, "chain_hit");
    set_wr(B + 14'd3, 1); set_rd(B + 14'd3, 32'hDEAD_BEEF, "rw_same_old"); clk1();
    rd(B + 14'd3, 1, "rw_same_new");
    wr(B + 14'd8, 0);
    rd(B, 1, "out_of_range_wr");
    t = 0;
    while ((rd_exp.size() != 0 || irq_exp.size() != 0) && t < 10) begin
      clk1();
      t++;
    end
    if (rd_exp.size() != 0 || irq_exp.size() != 0) begin
      errors++;
      checks++;
      $display("FAIL drain: rd_left=%0d irq_left=%0d expected 0", rd_exp.size(), irq_exp.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/io_timer_irq.md
# io_timer_irq

Memory-mapped interval timer on the CPU's dma_io peripheral bus, daisy-chained with io_led and io_uart_out on the read-data chain. It counts prescaled clock ticks, compares against a programmable value, latches a pending flag, and drives the level interrupt that feeds cpu_top's interrupt_0 input. It supports one-shot and periodic (auto-reload) modes and gives firmware a tick source that needs no external pin.

## Interface
- TIMER_BASE, 14'h3C00: word address [15:2] of register 0 (byte 0xF000); five consecutive words are decoded.
- clk  input  1  system clock, same domain as cpu_top.
- rst  input  1  synchronous active-high reset; the top level drives it from the inverted rst_n.
- dma_io_we  input  1  register write strobe, one cycle per write.
- dma_io_wadr  input  14  write word address [15:2].
- dma_io_wdata  input  32  write data.
- dma_io_radr  input  14  read word address [15:2].
- dma_io_radr_en  input  1  read request strobe.
- dma_io_rdata_in  input  32  read data from the next device in the chain.
- dma_io_rdata  output  32  chained read data toward cpu_top.
- timer_irq  output  1  level interrupt, registered.

## Operation
Registers, by word offset from TIMER_BASE:
- +0 CTRL, R/W:
  - bit0 EN: counting enable.
  - bit1 IE: interrupt enable.
  - bit2 AR: auto-reload.
  - bit3 CLR: write-only, self-clearing. Writing 1 zeroes COUNT and the prescaler. Reads as 0.
  - Other bits read as 0.
- +1 PRESCALE, R/W, bits [15:0]; upper bits read as 0.
- +2 COUNT, R/W, 32 bits.
- +3 COMPARE, R/W, 32 bits.
- +4 STATUS:
  - bit0 PEND, read; write 1 clears it (W1C).
  - bit1 EN mirror, read-only.

Prescaler and tick:
- A 16-bit prescaler counter runs while EN=1. When it equals PRESCALE, it returns to 0 and a one-cycle `tick` is asserted. Tick period is therefore PRESCALE+1 cycles.
- When EN=0, the prescaler is held at 0 and no tick occurs. COUNT and PEND keep their values.

On each tick:
- If COUNT == COMPARE, PEND is set. COUNT becomes 0 if AR=1, otherwise COUNT+1.
- If COUNT != COMPARE, COUNT becomes COUNT+1, modulo 2^32. 0xFFFFFFFF wraps to 0 and does not set PEND by itself.

Interrupt:
- timer_irq is registered: timer_irq <= PEND & IE.

Priority rules:
- A COUNT write or CLR in the same cycle as a tick wins; the tick's increment is discarded. The compare for that tick is still evaluated on the old COUNT.
- A PEND set and a W1C in the same cycle: the set wins, and PEND stays 1.
- A PRESCALE write zeroes the prescaler counter in that cycle.
- A write to an address outside the five registers is ignored.

Read chain:
- Each cycle, `hit_q` is registered as dma_io_radr_en AND dma_io_radr within [TIMER_BASE, TIMER_BASE+4].
- The addressed register's value is registered into `rdata_q` in the same cycle.
- dma_io_rdata = hit_q ? rdata_q : dma_io_rdata_in. This output is combinational, so the chain adds no latency.

Reset values:
- All registers, the prescaler, hit_q and rdata_q are 0.
- timer_irq is 0.
- dma_io_rdata equals dma_io_rdata_in.

## Timing
- Write: the register updates on the clk edge where dma_io_we=1 and is visible from the next cycle.
- Read: data appears on dma_io_rdata in the cycle after dma_io_radr_en, for one cycle only.
- A read and a write to the same register in the same cycle return the old value.
- Setting EN: the first tick occurs PRESCALE+1 cycles after the write cycle.
- From the tick with COUNT==COMPARE: PEND is 1 the next cycle, and timer_irq is 1 one cycle after that (2-cycle latency).
- Clearing PEND by W1C (with no set in the same cycle) drops timer_irq 2 cycles after the write.
- Reset asserted mid-count returns everything to reset values at the next edge. A read in flight is dropped: hit_q=0.

## Test plan
- Reset:
  - Stimulus: hold rst, drive dma_io_rdata_in=32'hA5A5_0001.
  - Required: timer_irq=0; dma_io_rdata=32'hA5A5_0001; reads of all five registers return 0.
- One-shot:
  - Stimulus: PRESCALE=3, COMPARE=5, CTRL=3 (EN|IE).
  - Required: PEND sets on the 6th tick, 24 cycles after the enable write. timer_irq rises 2 cycles later. COUNT reads 6 and keeps incrementing.
- Periodic:
  - Stimulus: PRESCALE=0, COMPARE=2, CTRL=7 (EN|IE|AR).
  - Required: COUNT sequence 0,1,2,0,1,2. PEND is set every 3 cycles.
  - Then W1C STATUS=1 at a cycle with no compare-match tick: PEND reads 0 and timer_irq falls 2 cycles after the write.
- Collisions:
  - A COUNT write of 32'h10 on a tick cycle: COUNT reads 32'h10.
  - A W1C in the same cycle as a compare-match tick: PEND remains 1.
- Wrap:
  - Stimulus: COUNT=32'hFFFF_FFFF, COMPARE=32'h0000_0005, PRESCALE=0, EN=1.
  - Required: the next tick gives COUNT=0 with PEND still 0. PEND sets on the tick where COUNT==5.
- Chain pass-through:
  - Stimulus: read of an address outside the five registers.
  - Required: dma_io_rdata equals dma_io_rdata_in.
  - A read at TIMER_BASE+3 with COMPARE=32'hDEAD_BEEF returns 32'hDEAD_BEEF one cycle after radr_en, regardless of dma_io_rdata_in.
